cmd_sequencer: RTL
==================

Name: cmd_sequencer

Overview:
- Command-issue front end that sits directly upstream of the compute core. It drives that core's command_in, command_we0 and command_we1 inputs and consumes its done_ins_computation output.
- The host pushes 35-bit instruction words {OP3[34:25], OP2[24:15], OP1[14:5], INS[4:0]} into an internal FIFO.
- The sequencer issues one instruction at a time and waits for done. It then writes an all-zero word to return every unit to reset, so the next instruction starts clean.
- Lets software queue a whole NTT/AES/TRNG program without polling between instructions.

Parameters:
- LOG_DEPTH, 4, log2 of FIFO depth (16 entries).
- GAP_CYCLES, 2, idle cycles after the clearing write before the next issue; range 1..15.
- TIMEOUT_CYCLES, 65535, WAIT-state watchdog limit; used only with CMDSEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push_valid  in  1  host offers push_cmd.
- push_cmd  in  35  instruction word.
- push_ready  out  1  FIFO can accept a word.
- run  in  1  level; issuing is permitted while high.
- done_ins_computation  in  1  completion from the compute core.
- command_in  out  35  command word to the compute core.
- command_we0  out  1  write strobe for command register 0.
- command_we1  out  1  write strobe for command register 1; held 0.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  LOG_DEPTH+1  occupancy.
- ins_count  out  16  instructions completed; wraps 65535->0.
- seq_done  out  1  one-cycle pulse when the FIFO drains after a completed instruction.
- err_unsupported  out  1  sticky; an unsupported INS was dropped.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): FIFO emptied, FSM->IDLE, gap counter and watchdog counter cleared, all outputs 0 including push_ready. After reset release, push_ready = !full.
- FIFO:
  - Push occurs when push_valid && push_ready.
  - push_ready is 0 when full, even if a pop happens in the same cycle.
  - A pop never coincides with empty.
  - A simultaneous push and pop keeps fifo_count unchanged.
- Supported INS values: 18, 19, 20, 22, 23, 24.
- FSM states:
  - IDLE: if run && !empty, examine the FIFO head.
    - Unsupported INS: pop it, do not issue, set err_unsupported, stay IDLE.
    - Supported INS: go to ISSUE.
  - ISSUE (1 cycle): command_in=head, command_we0=1, pop; -> WAIT.
  - WAIT:
    - command_we0=0.
    - The first WAIT cycle ignores done_ins_computation (core register loads on the ISSUE edge).
    - From the second cycle, done=1 -> CLEAR.
  - CLEAR (1 cycle): command_in=35'd0, command_we0=1, ins_count++; -> GAP.
  - GAP: count GAP_CYCLES cycles with we0=0, then -> IDLE. On GAP exit, seq_done pulses for 1 cycle if the FIFO is empty.
- command_in holds its last driven value while command_we0=0. command_we0 is asserted only in ISSUE and CLEAR.
- Minimum issue-to-issue period: 4 + GAP_CYCLES + core latency.
- Taking run low mid-instruction does not abort. The current instruction completes through CLEAR/GAP, and the FSM then holds in IDLE.
- Pushes are accepted in every state, including while run=0.
- The error flags clear only on reset.

Optional Feature:
- Macro: CMDSEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts WAIT cycles.
  - On reaching TIMEOUT_CYCLES without done, the FSM goes to CLEAR, sets err_timeout, and does not increment ins_count.
  - The FIFO is flushed, so fifo_count=0 and no seq_done pulse occurs.
- Undefined: WAIT has no time limit and err_timeout is tied to 0.

Test Plan:
- Single TRNG: push 0x00000112 (INS=18, OP1=8), run=1, done asserted 5 cycles after ISSUE -> we0 pulses with 0x112, then with 0x0; ins_count=1; seq_done pulses once after 2 GAP cycles.
- Back-to-back: push 0x18 (INS=24), then 0x16 (INS=22), with done at various latencies -> issue order 24, 22, each followed by a zero write; ins_count=2; exactly one seq_done pulse.
- FIFO full: 17 pushes with run=0 -> push_ready=0 after the 16th; fifo_count=16; 17th word not stored. With run=1, all 16 are issued in order.
- Unsupported: push INS=5, then INS=18 -> INS=5 never appears on command_in; err_unsupported=1; INS=18 still executes.
- Reset in WAIT: rst=0 for 1 cycle -> command_in=0, we0=0, busy=0, fifo_count=0, ins_count=0 immediately (asynchronous).
- With CMDSEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20: done never asserted, 3 queued -> CLEAR after 20 WAIT cycles; err_timeout=1; fifo_count=0; ins_count=0; no seq_done pulse.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Command-issue front end: queues 35-bit instructions, issues one at a time, clears the core after each.
// Optional WAIT-state watchdog enabled by defining CMDSEQ_TIMEOUT_EN.
module cmd_sequencer #(
  parameter int LOG_DEPTH  = 4,
  parameter int GAP_CYCLES = 2
`ifdef CMDSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [34:0]          push_cmd,
  output logic                 push_ready,
  input  logic                 run,
  input  logic                 done_ins_computation,
  output logic [34:0]          command_in,
  output logic                 command_we0,
  output logic                 command_we1,
  output logic                 busy,
  output logic [LOG_DEPTH:0]   fifo_count,
  output logic [15:0]          ins_count,
  output logic                 seq_done,
  output logic                 err_unsupported,
  output logic                 err_timeout
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_GAP} state_t;

  logic [34:0]          r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;
  logic                 r_ready_en;

  state_t               r_state;
  logic [34:0]          r_cmd;
  logic                 r_we0;
  logic [3:0]           r_gap_cnt;
  logic                 r_first_wait;
  logic [15:0]          r_ins_count;
  logic                 r_seq_done;
  logic                 r_err_unsup;
  logic                 r_aborted;

  logic [34:0]          w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_supported;
  logic                 w_done_ok;
  logic                 w_timeout;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_full      = (r_count == (LOG_DEPTH+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign push_ready  = r_ready_en && !w_full;
  assign w_push      = push_valid && push_ready;
  assign w_pop       = (r_state == S_IDLE) && run && !w_empty;
  assign w_supported = w_head[4:0] inside {5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24};
  // The core loads the command on the ISSUE edge, so done is only trusted from the second WAIT cycle.
  assign w_done_ok   = (r_state == S_WAIT) && !r_first_wait && done_ins_computation;

`ifdef CMDSEQ_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err_tmo;

  assign w_timeout   = (r_state == S_WAIT) && !w_done_ok && (r_wdog == 16'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_WAIT) ? r_wdog + 16'd1 : 16'd0;
      if (w_timeout) r_err_tmo <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_timeout) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_we0        <= 1'b0;
      r_gap_cnt    <= '0;
      r_first_wait <= 1'b0;
      r_ins_count  <= '0;
      r_seq_done   <= 1'b0;
      r_err_unsup  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_we0      <= 1'b0;
      r_seq_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_supported) begin
              r_state <= S_ISSUE;
              r_cmd   <= w_head;
              r_we0   <= 1'b1;
            end else begin
              r_err_unsup <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state      <= S_WAIT;
          r_first_wait <= 1'b1;
        end
        S_WAIT: begin
          r_first_wait <= 1'b0;
          if (w_done_ok || w_timeout) begin
            r_state   <= S_CLEAR;
            r_cmd     <= '0;
            r_we0     <= 1'b1;
            r_aborted <= w_timeout;
            if (!w_timeout) r_ins_count <= r_ins_count + 16'd1;
          end
        end
        S_CLEAR: begin
          r_state   <= S_GAP;
          r_gap_cnt <= '0;
        end
        S_GAP: begin
          if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            r_seq_done <= w_empty && !r_aborted;
            r_aborted  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign command_in      = r_cmd;
  assign command_we0     = r_we0;
  assign command_we1     = 1'b0;
  assign busy            = (r_state != S_IDLE);
  assign fifo_count      = r_count;
  assign ins_count       = r_ins_count;
  assign seq_done        = r_seq_done;
  assign err_unsupported = r_err_unsup;

endmodule
